// File: rtl/valu_sequencer_pkg.sv
// Shared constants for the vector ALU sequencer: ALU opcodes, FSM encoding and size defaults.
package valu_sequencer_pkg;

    localparam int unsigned VlmaxDefault = 32;
    localparam int unsigned AluOpW       = 4;

    localparam logic [AluOpW-1:0] AluAdd = 4'h0;
    localparam logic [AluOpW-1:0] AluSub = 4'h1;
    localparam logic [AluOpW-1:0] AluAnd = 4'h2;
    localparam logic [AluOpW-1:0] AluOr  = 4'h3;
    localparam logic [AluOpW-1:0] AluXor = 4'h4;
    localparam logic [AluOpW-1:0] AluSll = 4'h5;
    localparam logic [AluOpW-1:0] AluSrl = 4'h6;
    localparam logic [AluOpW-1:0] AluSra = 4'h7;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } valu_state_e;

endpackage

// File: rtl/valu_idx_counter.sv
// Element index counter: synchronous load, increment, saturating at the terminal index.
module valu_idx_counter #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [Width-1:0] last_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !tc_o) begin
            // Holding at the terminal index keeps the counter from wrapping.
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/valu_sequencer.sv
// Vector ALU sequencer: streams element reads through an external ALU and writes results back.
module valu_sequencer
    import valu_sequencer_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned VLMAX = VlmaxDefault
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [$clog2(VLMAX):0]   req_vl,
    input  logic                     abort,
    output logic [$clog2(VLMAX)-1:0] rd_idx,
    output logic                     rd_en,
    input  logic [N-1:0]             rd_a,
    input  logic [N-1:0]             rd_b,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    output logic [3:0]               alu_op,
    input  logic [N-1:0]             alu_out,
    input  logic                     alu_ovf,
    output logic                     wb_en,
    output logic [$clog2(VLMAX)-1:0] wb_idx,
    output logic [N-1:0]             wb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf_sticky
);

    localparam int unsigned IdxW = $clog2(VLMAX);
    localparam int unsigned VlW  = IdxW + 1;

    valu_state_e state_q, state_d;

    logic [3:0]      op_q, op_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] widx_q, widx_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;

    logic [IdxW-1:0] cnt;
    logic            tc;
    logic            accept;
    logic            abort_act;
    logic [VlW-1:0]  vl_clamp;

    valu_idx_counter #(
        .Width (IdxW)
    ) u_idx_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i ({IdxW{1'b0}}),
        .inc_i      (rd_en),
        .last_i     (last_q),
        .cnt_o      (cnt),
        .tc_o       (tc)
    );

    always_comb begin
        vl_clamp  = (req_vl > VlW'(VLMAX)) ? VlW'(VLMAX) : req_vl;
        abort_act = abort && ((state_q == StRun) || (state_q == StDrain));

        state_d   = state_q;
        accept    = 1'b0;
        req_ready = 1'b0;
        rd_en     = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (vl_clamp == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort_act) begin
                    state_d = StDone;
                end else begin
                    rd_en = 1'b1;
                    if (tc) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Write-back follows its read by one cycle; abort suppresses the in-flight element.
    always_comb begin
        wb_en   = valid_q && !abort_act;
        valid_d = rd_en;
        widx_d  = rd_en ? cnt : widx_q;
        op_d    = accept ? req_op : op_q;
        last_d  = accept ? IdxW'(vl_clamp - VlW'(1)) : last_q;

        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (wb_en && alu_ovf) begin
            ovf_d = 1'b1;
        end

        rd_idx     = rd_en ? cnt : '0;
        wb_idx     = wb_en ? widx_q : '0;
        wb_data    = wb_en ? alu_out : '0;
        alu_a      = valid_q ? rd_a : '0;
        alu_b      = valid_q ? rd_b : '0;
        alu_op     = valid_q ? op_q : 4'h0;
        ovf_sticky = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            last_q  <= '0;
            widx_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            last_q  <= last_d;
            widx_q  <= widx_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_valu_sequencer.sv
// Randomised self-checking bench for valu_sequencer with an external ALU and register file model.
module tb_valu_sequencer;
    import valu_sequencer_pkg::*;

    localparam int NW = 32;
    localparam int VL = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [3:0]      req_op = '0;
    logic [5:0]      req_vl = '0;
    logic            abort = 1'b0;
    logic [4:0]      rd_idx;
    logic            rd_en;
    logic [NW-1:0]   rd_a, rd_b;
    logic [NW-1:0]   alu_a, alu_b;
    logic [3:0]      alu_op;
    logic [NW-1:0]   alu_out;
    logic            alu_ovf;
    logic            wb_en;
    logic [4:0]      wb_idx;
    logic [NW-1:0]   wb_data;
    logic            busy, done, ovf_sticky;

    logic [NW-1:0]   va [VL];
    logic [NW-1:0]   vb [VL];
    int              n_total = 0;
    int              n_bad = 0;
    logic            sticky_m = 1'b0;

    valu_sequencer #(
        .N     (NW),
        .VLMAX (VL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_vl     (req_vl),
        .abort      (abort),
        .rd_idx     (rd_idx),
        .rd_en      (rd_en),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_ovf    (alu_ovf),
        .wb_en      (wb_en),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .busy       (busy),
        .done       (done),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Returns {overflow, result}; signed overflow for add/sub only.
    function automatic logic [32:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (op)
            AluAdd: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            AluSub: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            AluAnd: r = a & b;
            AluOr:  r = a | b;
            AluXor: r = a ^ b;
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    assign {alu_ovf, alu_out} = alu_calc(alu_op, alu_a, alu_b);

    // Register file: operands valid the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= va[rd_idx];
            rd_b <= vb[rd_idx];
        end else begin
            rd_a <= $urandom;
            rd_b <= $urandom;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " busy"}, 64'(busy), 64'd0);
        check_eq({tag, " done"}, 64'(done), 64'd0);
        check_eq({tag, " rd_en"}, 64'(rd_en), 64'd0);
        check_eq({tag, " wb_en"}, 64'(wb_en), 64'd0);
        check_eq({tag, " rd_idx"}, 64'(rd_idx), 64'd0);
        check_eq({tag, " wb_idx"}, 64'(wb_idx), 64'd0);
        check_eq({tag, " wb_data"}, 64'(wb_data), 64'd0);
        check_eq({tag, " alu_a"}, 64'(alu_a), 64'd0);
        check_eq({tag, " alu_b"}, 64'(alu_b), 64'd0);
        check_eq({tag, " alu_op"}, 64'(alu_op), 64'd0);
        check_eq({tag, " ovf_sticky"}, 64'(ovf_sticky), 64'(sticky_m));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            req_valid = 1'b0;
            req_op    = 4'($urandom);
            req_vl    = 6'($urandom);
            abort     = 1'($urandom);
            @(negedge clk);
            check_eq("idle req_ready", 64'(req_ready), 64'd1);
            check_zero("idle");
            @(posedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < VL; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
    endtask

    // One request; ka = cycle after acceptance carrying abort (0 = none).
    task automatic run_op(input logic [3:0] op, input int vl_raw, input int ka, input bit hold,
                          input bit abort_done);
        int          vl, done_k, i;
        bit          rd_now, rd_prev, wb_now;
        logic [32:0] r;
        vl     = (vl_raw > VL) ? VL : vl_raw;
        done_k = (vl == 0) ? 1 : ((ka != 0) ? ka + 1 : vl + 2);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_vl    = 6'(vl_raw);
        abort     = 1'($urandom);
        @(negedge clk);
        for (int w = 0; w < 20 && !req_ready; w++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        check_eq("accept req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        sticky_m = 1'b0;
        for (int k = 1; k <= done_k; k++) begin
            #1;
            req_valid = hold;
            req_op    = 4'($urandom);
            req_vl    = 6'($urandom);
            abort     = (k == ka) || (abort_done && k == done_k);
            @(negedge clk);
            rd_now  = (k >= 1) && (k <= vl) && (ka == 0 || k < ka);
            rd_prev = (k >= 2) && (k - 1 <= vl) && (ka == 0 || k - 1 < ka);
            wb_now  = rd_prev && (k != ka);
            i = k - 2;
            r = '0;
            if (wb_now) r = alu_calc(op, va[i], vb[i]);
            check_eq($sformatf("req_ready k=%0d", k), 64'(req_ready), 64'd0);
            check_eq($sformatf("busy k=%0d", k), 64'(busy), 64'd1);
            check_eq($sformatf("done k=%0d", k), 64'(done), 64'(k == done_k));
            check_eq($sformatf("rd_en k=%0d", k), 64'(rd_en), 64'(rd_now));
            check_eq($sformatf("rd_idx k=%0d", k), 64'(rd_idx), rd_now ? 64'(k - 1) : 64'd0);
            check_eq($sformatf("wb_en k=%0d", k), 64'(wb_en), 64'(wb_now));
            check_eq($sformatf("wb_idx k=%0d", k), 64'(wb_idx), wb_now ? 64'(i) : 64'd0);
            check_eq($sformatf("wb_data k=%0d", k), 64'(wb_data), 64'(r[31:0]));
            check_eq($sformatf("alu_a k=%0d", k), 64'(alu_a), rd_prev ? 64'(va[i]) : 64'd0);
            check_eq($sformatf("alu_b k=%0d", k), 64'(alu_b), rd_prev ? 64'(vb[i]) : 64'd0);
            check_eq($sformatf("alu_op k=%0d", k), 64'(alu_op), rd_prev ? 64'(op) : 64'd0);
            check_eq($sformatf("ovf_sticky k=%0d", k), 64'(ovf_sticky), 64'(sticky_m));
            if (wb_now) sticky_m = sticky_m | r[32];
            @(posedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic reset_mid_run();
        fill_rand();
        #1;
        req_valid = 1'b1;
        req_op    = AluAdd;
        req_vl    = 6'd8;
        abort     = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        sticky_m = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("post_rst req_ready", 64'(req_ready), 64'd1);
            check_zero("post_rst");
            @(posedge clk);
        end
    endtask

    initial begin
        int  vlr, ka;
        bit  hold;
        logic [3:0] op;
        logic [3:0] ops [5];
        ops[0] = AluAdd; ops[1] = AluSub; ops[2] = AluAnd; ops[3] = AluOr; ops[4] = AluXor;

        #3;
        check_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("por req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);

        for (int i = 0; i < VL; i++) begin
            va[i] = 32'(i + 1);
            vb[i] = 32'd10;
        end
        run_op(AluAdd, 4, 0, 1'b0, 1'b0);
        idle(2);
        run_op(AluAdd, 0, 0, 1'b0, 1'b0);
        idle(1);

        fill_rand();
        va[0] = 32'd5;          vb[0] = 32'd1;
        va[1] = 32'h8000_0000;  vb[1] = 32'd1;
        va[2] = 32'd7;          vb[2] = 32'd2;
        run_op(AluSub, 3, 0, 1'b0, 1'b0);
        idle(2);
        check_eq("sticky after sub", 64'(ovf_sticky), 64'd1);
        run_op(AluXor, 2, 0, 1'b0, 1'b0);
        idle(1);

        fill_rand();
        run_op(AluAdd, 8, 3, 1'b0, 1'b0);
        idle(1);
        fill_rand();
        run_op(AluSub, 5, 6, 1'b0, 1'b0);
        idle(1);

        reset_mid_run();
        idle(1);

        fill_rand();
        run_op(AluOr, VL, 0, 1'b1, 1'b1);
        fill_rand();
        run_op(AluAnd, 5, 0, 1'b0, 1'b0);
        idle(1);
        fill_rand();
        run_op(AluAdd, 40, 0, 1'b0, 1'b0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            fill_rand();
            op   = ops[$urandom_range(0, 4)];
            vlr  = $urandom_range(0, 40);
            ka   = 0;
            if (vlr > 0 && ($urandom % 4) == 0) begin
                ka = $urandom_range(1, ((vlr > VL) ? VL : vlr) + 1);
            end
            hold = (($urandom % 3) == 0);
            run_op(op, vlr, ka, hold, (($urandom % 3) == 0));
            if (!hold) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/valu_sequencer.md
VALU_SEQUENCER -- requirements
Module: valu_sequencer

Interface
REQ-001 Parameters SHALL be: N (default 32), the element width in bits; VLMAX (default 32), the maximum vector length in elements.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  vector op request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  4  ALU opcode, shared ALU opcode encoding
- req_vl  in  $clog2(VLMAX)+1  element count, 0..VLMAX
- abort  in  1  kill the current op
- rd_idx  out  $clog2(VLMAX)  element index to the vector register file read port
- rd_en  out  1  read strobe
- rd_a, rd_b  in  N  operands, valid the cycle after rd_en
- alu_a, alu_b  out  N  operands to the shared combinational ALU
- alu_op  out  4  opcode to the ALU
- alu_out  in  N  ALU result
- alu_ovf  in  1  ALU overflow
- wb_en  out  1  write strobe
- wb_idx  out  $clog2(VLMAX)  write element index
- wb_data  out  N  write data
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- ovf_sticky  out  1  OR of alu_ovf over all written elements of the last op

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-004 In IDLE, req_ready SHALL be 1 and all other outputs except ovf_sticky SHALL be 0.
REQ-005 On acceptance, the block SHALL latch req_op and req_vl, and clear ovf_sticky.
- If vl>0, the FSM SHALL go to RUN.
- If vl==0, the FSM SHALL go to DONE and issue no rd_en or wb_en.
REQ-006 In RUN, the block SHALL assert rd_en every cycle with rd_idx = 0, 1, ..., vl-1, one index per cycle.
- After the cycle that issues index vl-1, the FSM SHALL go to DRAIN.
REQ-007 A one-bit valid pipeline register and an index register SHALL track each read.
- In the cycle after a read, alu_a = rd_a, alu_b = rd_b and alu_op = the latched op.
- In that same cycle, wb_en = 1, wb_idx = the read index, and wb_data = alu_out.
REQ-008 Each element's write SHALL occur exactly one cycle after its read, so the writes are back-to-back with no gaps.
- The last write SHALL occur vl+1 cycles after the acceptance edge.
REQ-009 DRAIN SHALL last exactly one cycle, carrying the final write-back, and then go to DONE.
REQ-010 DONE SHALL last one cycle with done = 1, then go to IDLE.
- req_ready SHALL be 0 in DONE; a new request is accepted no earlier than the following IDLE cycle.
REQ-011 ovf_sticky SHALL be set on any wb_en cycle where alu_ovf = 1, and SHALL hold its value until the next acceptance.
REQ-012 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-013 abort in RUN or DRAIN SHALL take effect in the same cycle:
- wb_en and rd_en forced to 0;
- the valid pipeline register cleared;
- a transition to DONE, with done pulsing next cycle.
- abort in IDLE or DONE SHALL be ignored.
REQ-014 alu_a, alu_b and alu_op SHALL be 0 whenever the valid pipeline register is 0, so the ALU sees no spurious activity.
REQ-015 vl > VLMAX SHALL be clamped to VLMAX at latch time.
REQ-016 The element index counter SHALL not wrap; vl = VLMAX SHALL issue indices up to VLMAX-1 and stop.

Reset
REQ-017 rst_n low SHALL asynchronously force:
- the FSM to IDLE;
- all counters, the valid register, ovf_sticky, done, busy, rd_en and wb_en to 0;
- req_ready to 1 after deassertion.
REQ-018 Reset mid-operation SHALL discard the op with no further writes and no done pulse.

Structure
REQ-019 The FSM state encoding and the VLMAX default SHALL reside in the shared package/constants include alongside the existing ALU opcode defines.
REQ-020 The ALU itself SHALL remain external; the block contains only sequencing.
REQ-021 One sub-module, valu_idx_counter (load, increment, terminal-count flag), SHALL be used for the element index.

Verification
REQ-022 ADD with vl=4, rd_a = {1,2,3,4}, rd_b = 10 and ALU modelled: the bench SHALL see wb_en for 4 consecutive cycles with wb_data = 11, 12, 13, 14 at wb_idx 0..3, and done exactly 6 cycles after acceptance.
REQ-023 vl=0: the bench SHALL see no rd_en and no wb_en, done 1 cycle after acceptance, and busy high for 1 cycle.
REQ-024 SUB with vl=3 and alu_ovf=1 on element 1 only: the bench SHALL see ovf_sticky = 1 after done, and ovf_sticky cleared on the next acceptance.
REQ-025 abort asserted on the 3rd RUN cycle of vl=8: the bench SHALL see no wb_en from that cycle on, done the next cycle, and return to IDLE.
REQ-026 rst_n pulsed low mid-RUN: the bench SHALL see all outputs 0 immediately, with req_ready = 1 after release.
REQ-027 vl=VLMAX, then a back-to-back request held valid: the bench SHALL see rd_idx stop at VLMAX-1 and the second request accepted in the first IDLE cycle after done.
